// File: rtl/issue_pkg.sv
// Shared definitions for the issue stage: immediate-mode encodings and the
// default-width scoreboard vector type.
package issue_pkg;

  // Immediate extension modes carried by dec_imm_mode.
  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_RSVD  = 2'd3
  } imm_mode_e;

  // Default register-id width and the matching one-bit-per-register vector.
  localparam int DEF_REG_AW = 6;
  typedef logic [(2**DEF_REG_AW)-1:0] sb_vec_t;

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extender: sign, zero or upper placement of the
// raw decode immediate into a DATA_W-bit operand. The reserved mode yields 0.
module imm_ext
  import issue_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] ext_imm
);

  localparam int PAD_W = DATA_W - IMM_W;

  // Select the extension form from the mode encoding.
  always_comb begin
    ext_imm = '0;
    case (imm_mode_e'(mode))
      IMM_SEXT:  ext_imm = {{PAD_W{imm[IMM_W-1]}}, imm};
      IMM_ZEXT:  ext_imm = {{PAD_W{1'b0}}, imm};
      IMM_UPPER: ext_imm = {imm, {PAD_W{1'b0}}};
      default:   ext_imm = '0;
    endcase
  end

endmodule

// File: rtl/issue_sb.sv
// Issue stage with a register scoreboard. Takes one decoded op per cycle,
// stalls it while any register it reads or writes has an outstanding write,
// and registers the accepted op (with its extended immediate) for execute.
//
// Handshakes: both the decode side (dec_valid/dec_ready) and the execute side
// (iss_valid/iss_ready) transfer on a cycle where valid and ready are both 1.
// A valid producer holds its payload stable until that cycle; dec_ready is
// combinational and never depends on dec_valid.
module issue_sb
  import issue_pkg::*;
#(
  parameter int REG_AW   = 6,
  parameter int IMM_W    = 16,
  parameter int DATA_W   = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_use_rs,
  input  logic              dec_use_rt,
  input  logic              dec_wr_rd,
  input  logic [IMM_W-1:0]  dec_imm,
  input  logic [1:0]        dec_imm_mode,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [REG_AW-1:0] rd_reg1_iss,
  output logic [REG_AW-1:0] rd_reg2_iss,
  output logic [REG_AW-1:0] wr_reg_iss,
  output logic              wr_en_iss,
  output logic [DATA_W-1:0] ext_imm_iss,
  output logic [31:0]       stall_cnt
);

  localparam int SB_N = 2**REG_AW;
  localparam logic [SB_N-1:0] SB_ONE = {{(SB_N-1){1'b0}}, 1'b1};

  typedef logic [SB_N-1:0] sb_t;

  sb_t               sb;
  sb_t               wb_clr;
  sb_t               kill_clr;
  sb_t               fire_set;
  sb_t               busy_eff;
  sb_t               sb_next;
  logic              hazard;
  logic              slot_free;
  logic              fire;
  logic              set_ok;
  logic [DATA_W-1:0] ext_imm;

  imm_ext #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_imm_ext (
    .imm     (dec_imm),
    .mode    (dec_imm_mode),
    .ext_imm (ext_imm)
  );

  // Hazard check against the scoreboard, with same-cycle writeback already retired.
  always_comb begin
    wb_clr    = wb_valid ? (SB_ONE << wb_reg) : '0;
    busy_eff  = sb & ~wb_clr;
    hazard    = (dec_use_rs & busy_eff[dec_rs]) |
                (dec_use_rt & busy_eff[dec_rt]) |
                (dec_wr_rd  & busy_eff[dec_rd]);
    slot_free = ~iss_valid | iss_ready;
    dec_ready = slot_free & ~hazard & ~flush & ~reset;
    fire      = dec_valid & dec_ready;
  end

  // Next scoreboard: retire writebacks and flushed writes first, then mark the new
  // destination busy so a set on the same register wins. Register 0 stays clear
  // when it is hardwired to zero.
  always_comb begin
    set_ok   = !((ZERO_REG != 0) && (dec_rd == '0));
    kill_clr = (flush & iss_valid & wr_en_iss) ? (SB_ONE << wr_reg_iss) : '0;
    fire_set = (fire & dec_wr_rd & set_ok) ? (SB_ONE << dec_rd) : '0;
    sb_next  = (sb & ~wb_clr & ~kill_clr) | fire_set;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  // Output op register: load on fire, drop valid when execute takes it or on flush,
  // otherwise hold the payload stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      iss_valid   <= 1'b0;
      rd_reg1_iss <= '0;
      rd_reg2_iss <= '0;
      wr_reg_iss  <= '0;
      wr_en_iss   <= 1'b0;
      ext_imm_iss <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (fire) begin
      iss_valid   <= 1'b1;
      rd_reg1_iss <= dec_rs;
      rd_reg2_iss <= dec_rt;
      wr_reg_iss  <= dec_rd;
      wr_en_iss   <= dec_wr_rd;
      ext_imm_iss <= ext_imm;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered op was blocked only by a hazard.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (dec_valid & hazard & slot_free & ~flush) begin
      if (stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_issue_sb.sv
// Self-checking bench for issue_sb: directed scenarios followed by random
// traffic, all checked against a behavioural model of the issue stage.
module tb_issue_sb;

  localparam int OP_W = 6 + 6 + 6 + 1 + 32;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_rs;
  logic [5:0]  dec_rt;
  logic [5:0]  dec_rd;
  logic        dec_use_rs;
  logic        dec_use_rt;
  logic        dec_wr_rd;
  logic [15:0] dec_imm;
  logic [1:0]  dec_imm_mode;
  logic        wb_valid;
  logic [5:0]  wb_reg;
  logic        iss_valid;
  logic        iss_ready;
  logic [5:0]  rd_reg1_iss;
  logic [5:0]  rd_reg2_iss;
  logic [5:0]  wr_reg_iss;
  logic        wr_en_iss;
  logic [31:0] ext_imm_iss;
  logic [31:0] stall_cnt;

  issue_sb #(
    .REG_AW   (6),
    .IMM_W    (16),
    .DATA_W   (32),
    .ZERO_REG (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_rs       (dec_rs),
    .dec_rt       (dec_rt),
    .dec_rd       (dec_rd),
    .dec_use_rs   (dec_use_rs),
    .dec_use_rt   (dec_use_rt),
    .dec_wr_rd    (dec_wr_rd),
    .dec_imm      (dec_imm),
    .dec_imm_mode (dec_imm_mode),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .rd_reg1_iss  (rd_reg1_iss),
    .rd_reg2_iss  (rd_reg2_iss),
    .wr_reg_iss   (wr_reg_iss),
    .wr_en_iss    (wr_en_iss),
    .ext_imm_iss  (ext_imm_iss),
    .stall_cnt    (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int unsigned n_vec;
  int unsigned n_err;

  logic [OP_W-1:0] exp_q[$];   // expected contents of the output op register
  bit              m_busy[64]; // registers with an outstanding write
  bit              m_valid;
  longint          m_stall;
  bit              m_ready;
  bit              m_hazard;
  bit              m_slot;
  logic            seen_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
    longint v;
    v = 0;
    case (mode)
      2'd0: v = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
      2'd1: v = longint'(imm);
      2'd2: v = longint'(imm) * 65536;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [63:0] busy_vec();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit busy_now(input logic [5:0] r);
    return m_busy[r] && !(wb_valid && wb_reg == r);
  endfunction

  // Decide from the current inputs whether the offered op may issue.
  task automatic model_comb();
    m_hazard = (dec_use_rs && busy_now(dec_rs)) ||
               (dec_use_rt && busy_now(dec_rt)) ||
               (dec_wr_rd  && busy_now(dec_rd));
    m_slot   = !m_valid || iss_ready;
    m_ready  = m_slot && !m_hazard && !flush && !reset;
  endtask

  // Advance the model by one clock edge.
  task automatic model_next();
    bit fire;
    logic [OP_W-1:0] cur;
    cur  = exp_q[0];
    fire = dec_valid && m_ready;
    if (reset) begin
      for (int i = 0; i < 64; i++) m_busy[i] = 1'b0;
      m_valid = 1'b0;
      m_stall = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      if (dec_valid && m_hazard && m_slot && !flush && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (wb_valid) m_busy[wb_reg] = 1'b0;
      if (flush && m_valid && cur[32]) m_busy[cur[38:33]] = 1'b0;
      if (fire && dec_wr_rd && dec_rd != 0) m_busy[dec_rd] = 1'b1;
      if (flush) begin
        m_valid = 1'b0;
      end else if (fire) begin
        m_valid = 1'b1;
        exp_q.delete();
        exp_q.push_back({dec_rs, dec_rt, dec_rd, dec_wr_rd, ext_model(dec_imm, dec_imm_mode)});
      end else if (iss_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reset = 0; flush = 0; dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rd = 0;
    dec_use_rs = 0; dec_use_rt = 0; dec_wr_rd = 0; dec_imm = 0; dec_imm_mode = 0;
    wb_valid = 0; wb_reg = 0; iss_ready = 0;
  endtask

  task automatic offer(input logic [5:0] rs, input logic use_rs, input logic [5:0] rd,
                       input logic wr, input logic [15:0] imm, input logic [1:0] mode);
    dec_valid = 1; dec_rs = rs; dec_use_rs = use_rs; dec_rt = 0; dec_use_rt = 0;
    dec_rd = rd; dec_wr_rd = wr; dec_imm = imm; dec_imm_mode = mode;
  endtask

  // Entered just after a falling edge with inputs applied; returns at the next one.
  task automatic step();
    #1;
    model_comb();
    seen_ready = dec_ready;
    check("dec_ready", {63'd0, dec_ready}, {63'd0, m_ready});
    model_next();
    @(posedge clk);
    #1;
    check("iss_valid", {63'd0, iss_valid}, {63'd0, m_valid});
    check("iss_op", {13'd0, rd_reg1_iss, rd_reg2_iss, wr_reg_iss, wr_en_iss, ext_imm_iss},
          {13'd0, exp_q[0]});
    check("sb", dut.sb, busy_vec());
    check("stall_cnt", {32'd0, stall_cnt}, m_stall[63:0]);
    @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    m_valid = 0;
    m_stall = 0;
    for (int i = 0; i < 64; i++) m_busy[i] = 0;
    exp_q.push_back('0);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    step();
    step();
    check("rst_valid", {63'd0, iss_valid}, 64'd0);
    check("rst_stall", {32'd0, stall_cnt}, 64'd0);
    reset = 0;

    // 1: write to r5 with sign-extended immediate
    offer(6'd0, 0, 6'd5, 1, 16'hFFF0, 2'd0);
    step();
    check("t1_valid", {63'd0, iss_valid}, 64'd1);
    check("t1_wr_reg", {58'd0, wr_reg_iss}, 64'd5);
    check("t1_ext", {32'd0, ext_imm_iss}, 64'hFFFF_FFF0);
    check("t1_sb5", {63'd0, dut.sb[5]}, 64'd1);

    // 2: read r5 while busy stalls; same-cycle writeback lets it issue
    iss_ready = 1;
    offer(6'd5, 1, 6'd0, 0, 16'h0001, 2'd1);
    step();
    check("t2_stall_ready", {63'd0, seen_ready}, 64'd0);
    check("t2_stall_cnt", {32'd0, stall_cnt}, 64'd1);
    wb_valid = 1; wb_reg = 6'd5;
    step();
    wb_valid = 0;
    check("t2_wb_ready", {63'd0, seen_ready}, 64'd1);
    check("t2_rs", {58'd0, rd_reg1_iss}, 64'd5);

    // 3: execute back-pressure holds the op; release issues the waiting op at once
    iss_ready = 0;
    offer(6'd1, 1, 6'd9, 1, 16'h1234, 2'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_hold_ready", {63'd0, seen_ready}, 64'd0);
      check("t3_hold_rs", {58'd0, rd_reg1_iss}, 64'd5);
    end
    iss_ready = 1;
    step();
    check("t3_go_ready", {63'd0, seen_ready}, 64'd1);
    check("t3_wr_reg", {58'd0, wr_reg_iss}, 64'd9);
    check("t3_sb9", {63'd0, dut.sb[9]}, 64'd1);

    // 4: flush kills the pending write to r9
    iss_ready = 0;
    flush = 1;
    offer(6'd2, 1, 6'd3, 1, 16'h0002, 2'd1);
    step();
    flush = 0;
    check("t4_ready", {63'd0, seen_ready}, 64'd0);
    check("t4_valid", {63'd0, iss_valid}, 64'd0);
    check("t4_sb9", {63'd0, dut.sb[9]}, 64'd0);

    // 5: r0 never becomes busy; zero and upper extension
    iss_ready = 1;
    offer(6'd0, 0, 6'd0, 1, 16'h8001, 2'd1);
    step();
    check("t5_zext", {32'd0, ext_imm_iss}, 64'h0000_8001);
    check("t5_sb0", {63'd0, dut.sb[0]}, 64'd0);
    offer(6'd0, 1, 6'd0, 0, 16'h8001, 2'd2);
    step();
    check("t5_r0_ready", {63'd0, seen_ready}, 64'd1);
    check("t5_upper", {32'd0, ext_imm_iss}, 64'h8001_0000);

    // 6: reset with busy registers and a held op, then counter saturation
    iss_ready = 0;
    offer(6'd0, 0, 6'd3, 1, 16'h7777, 2'd0);
    step();
    reset = 1;
    step();
    reset = 0;
    check("t6_valid", {63'd0, iss_valid}, 64'd0);
    check("t6_ext", {32'd0, ext_imm_iss}, 64'd0);
    check("t6_sb", dut.sb, 64'd0);
    iss_ready = 1;
    offer(6'd0, 0, 6'd4, 1, 16'h0004, 2'd1);
    step();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    m_stall = 64'hFFFF_FFFE;
    offer(6'd4, 1, 6'd0, 0, 16'h0005, 2'd1);
    for (int k = 0; k < 3; k++) step();
    check("t6_sat", {32'd0, stall_cnt}, 64'hFFFF_FFFF);

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_rs       = 6'($urandom_range(0, 7));
      dec_rt       = 6'($urandom_range(0, 7));
      dec_rd       = 6'($urandom_range(0, 7));
      dec_use_rs   = 1'($urandom_range(0, 1));
      dec_use_rt   = 1'($urandom_range(0, 1));
      dec_wr_rd    = 1'($urandom_range(0, 1));
      dec_imm      = 16'($urandom);
      dec_imm_mode = 2'($urandom_range(0, 3));
      wb_valid     = 1'($urandom_range(0, 1));
      wb_reg       = 6'($urandom_range(0, 7));
      iss_ready    = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
